hmac_msg_sequencer: RTL and testbench
=====================================

Name: hmac_msg_sequencer

Overview:
- Initiator-side front end for the HMAC-384 core.
- Accepts an arbitrary-length message as a 32-bit word stream and packs it into 1024-bit blocks.
- Applies SHA-384 final padding, with the length field counting the ipad key block.
- Issues init/next commands to the core block by block and returns the final 384-bit tag with a valid pulse.

Parameters:
- WORD_W, 32, input stream word width in bits; fixed, only 32 supported.
- BLK_WORDS, 32, words per 1024-bit block.
- LEN_W, 64, width of the internal message byte counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- zeroize  in  1  synchronous clear of all state, block buffer and tag
- s_valid  in  1  message word valid
- s_ready  out  1  sequencer accepts word
- s_data  in  32  message word, big-endian; first byte in [31:24]
- s_last  in  1  final word of message
- s_last_bytes  in  2  valid bytes in final word; 0 means 4
- core_init_cmd  out  1  one-cycle pulse, first block
- core_next_cmd  out  1  one-cycle pulse, subsequent blocks
- core_ready  in  1  core idle
- core_tag_valid  in  1  core tag valid
- core_block_msg  out  1024  block to core; word 0 at [1023:992]
- core_tag  in  384  tag from core
- tag  out  384  registered final tag
- tag_valid  out  1  held high from tag capture until next message starts
- busy  out  1  message in progress

Behaviour:
- Reset/zeroize values: all outputs 0, state IDLE, block buffer 0, byte counter 0, first_blk flag 1.
- States:
  - IDLE: s_ready=1. First accepted word clears tag_valid, sets busy, goes to FILL.
  - FILL: s_ready=1. Each accepted word is written to buffer slot wptr, wptr increments, counter += 4 (or s_last_bytes on last).
    - Slot 31 filled without last: go to ISSUE.
    - Last accepted: write the 0x80 byte immediately after the final valid byte, zero the rest of that word, zero the remaining slots, go to PADCHK.
  - PADCHK: if free bytes after 0x80 are >= 16 (0x80 landed at byte index <= 111), place the 128-bit length in slots 28..31 and mark final; otherwise mark final-pending-extra. Go to ISSUE.
  - ISSUE: s_ready=0. Wait for core_ready=1, then pulse core_init_cmd if first_blk else core_next_cmd. Clear first_blk, go to WAIT.
  - WAIT: ignore core signals for the issue cycle plus 1. Then wait for core_ready & core_tag_valid.
    - If not final: clear buffer, wptr=0, return to FILL (or EXTRA if pending).
    - If final: go to DONE.
  - EXTRA: build a block of zeros with the length in slots 28..31, mark final, go to ISSUE.
  - DONE: tag <= core_tag, tag_valid=1, busy=0, first_blk=1, counter=0, go to IDLE.
- Length field: 128 bits = ({counter,3'b0} + 1024), zero-extended.
- Latency: s_ready=0 from ISSUE until the block completes; buffer and core_block_msg are stable for that whole period.
- Boundary cases:
  - Last word filling slot 31 exactly: 0x80 goes into an extra block, which also carries the length.
  - Zero-length messages are unsupported; s_last on the first word with s_last_bytes=1 is the minimum.
  - s_valid with s_ready=0 is held off, with no data loss.
  - zeroize mid-operation aborts immediately: no further commands are issued and the core is zeroized by the same signal.
- core_init_cmd and core_next_cmd are never both high.

Optional Feature:
- Macro: HMAC_SEQ_TAG_VERIFY_EN.
- Enabled:
  - Adds input exp_tag[383:0] and outputs tag_match and tag_mismatch.
  - In DONE, compare core_tag to exp_tag using a full-width XOR-OR reduction with no early exit.
  - tag_match or tag_mismatch is registered alongside tag_valid and cleared with it.
  - Mismatch forces the tag output to 0.
- Disabled: ports absent, no comparator.

Decomposition:
- Package hmac_seq_pkg holds:
  - state enum;
  - SHA384 block bits (1024), length field bits (128), pad byte 8'h80;
  - KEY_BLOCK_BITS = 1024.
- Sub-module hmac_seq_padder: combinational pad-byte insertion, length placement and fits/extra decision, given wptr and last_bytes.

Test Plan:
- 3-byte message "abc" (s_data=32'h61626300, last_bytes=3) -> single init_cmd; block word0=32'h61626380, words 28..31 = length 128'h418; tag matches the HMAC-SHA384 golden model.
- 112-byte message (28 words) -> 0x80 at byte 112, no room for length -> init then next, second block all zero except length 128'h780.
- 256-byte message -> init, next, next; third block starts 0x80000000 with length 128'hC00; s_ready is low during each core operation.
- Back-to-back messages -> tag_valid drops on the first word of message 2; second tag is correct and first_blk causes an init_cmd.
- zeroize asserted in WAIT -> all outputs 0 next cycle, no further commands issued, next message still processes correctly.
- With HMAC_SEQ_TAG_VERIFY_EN, exp_tag with one bit flipped -> tag_mismatch=1, tag=0.

Source files
------------

// File: rtl/hmac_seq_pkg.sv
// Shared constants for the HMAC-384 message sequencer: FSM state encodings,
// SHA-384 block geometry, padding constants and the tag comparison helper.
package hmac_seq_pkg;

    localparam int SHA384_BLOCK_BITS = 1024;
    localparam int LEN_FIELD_BITS    = 128;
    localparam int KEY_BLOCK_BITS    = 1024;
    localparam int TAG_BITS          = 384;

    localparam logic [7:0]  PAD_BYTE      = 8'h80;
    localparam logic [31:0] PAD_WORD      = {PAD_BYTE, 24'h000000};
    // Highest byte index the 0x80 marker may occupy and still leave 16 bytes
    // for the length field in the same block.
    localparam logic [7:0]  PAD_FIT_LIMIT = 8'd111;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE   = 3'd0;
    localparam seq_state_t ST_FILL   = 3'd1;
    localparam seq_state_t ST_PADCHK = 3'd2;
    localparam seq_state_t ST_ISSUE  = 3'd3;
    localparam seq_state_t ST_WAIT   = 3'd4;
    localparam seq_state_t ST_EXTRA  = 3'd5;
    localparam seq_state_t ST_DONE   = 3'd6;

    // Full-width difference detect: every bit participates, no early exit.
    function automatic logic tag_differs(input logic [TAG_BITS-1:0] a,
                                         input logic [TAG_BITS-1:0] b);
        return |(a ^ b);
    endfunction

endpackage

// File: rtl/hmac_seq_padder.sv
// Combinational SHA-384 padding helper: inserts the 0x80 marker into the
// final message word, reports where the marker lands, decides whether the
// 128-bit length field still fits in the current block and builds that field
// (message bytes plus the ipad key block, in bits).
module hmac_seq_padder
    import hmac_seq_pkg::*;
#(
    parameter int LEN_W = 64,
    parameter int PTR_W = 5
) (
    input  logic [31:0]               data_i,
    input  logic [1:0]                last_bytes_i,
    input  logic [PTR_W-1:0]          wptr_i,
    input  logic [LEN_W-1:0]          cnt_i,
    input  logic [PTR_W+2:0]          pad_pos_i,
    output logic [31:0]               pad_word_o,
    output logic [2:0]                nbytes_o,
    output logic [PTR_W+2:0]          pad_pos_o,
    output logic                      spill_o,
    output logic                      spill_extra_o,
    output logic                      fits_o,
    output logic [LEN_FIELD_BITS-1:0] len_o
);

    // Marker insertion, marker position and length-field construction.
    always_comb begin
        nbytes_o = (last_bytes_i == 2'd0) ? 3'd4 : {1'b0, last_bytes_i};
        case (last_bytes_i)
            2'd1:    pad_word_o = {data_i[31:24], PAD_BYTE, 16'h0000};
            2'd2:    pad_word_o = {data_i[31:16], PAD_BYTE, 8'h00};
            2'd3:    pad_word_o = {data_i[31:8], PAD_BYTE};
            2'd0:    pad_word_o = data_i;
            default: pad_word_o = data_i;
        endcase
        pad_pos_o     = {1'b0, wptr_i, 2'b00} + {{PTR_W{1'b0}}, nbytes_o};
        // A full final word pushes the marker into the following slot; from
        // the last slot it has to move into an extra block.
        spill_o       = (last_bytes_i == 2'd0);
        spill_extra_o = spill_o && (wptr_i == {PTR_W{1'b1}});
        fits_o        = (pad_pos_i <= PAD_FIT_LIMIT);
        len_o         = (LEN_FIELD_BITS'(cnt_i) << 3'd3) + LEN_FIELD_BITS'(KEY_BLOCK_BITS);
    end

endmodule

// File: rtl/hmac_msg_sequencer.sv
// HMAC-384 initiator front end: packs a 32-bit big-endian word stream into
// 1024-bit blocks, applies SHA-384 final padding (length counts the ipad key
// block), drives init/next commands block by block and returns the tag.
// Optional build macro HMAC_SEQ_TAG_VERIFY_EN adds an expected-tag compare
// (exp_tag in, tag_match/tag_mismatch out; a mismatch suppresses the tag).
module hmac_msg_sequencer
    import hmac_seq_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int BLK_WORDS = 32,
    parameter int LEN_W     = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         zeroize,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [WORD_W-1:0]            s_data,
    input  logic                         s_last,
    input  logic [1:0]                   s_last_bytes,
    output logic                         core_init_cmd,
    output logic                         core_next_cmd,
    input  logic                         core_ready,
    input  logic                         core_tag_valid,
    output logic [SHA384_BLOCK_BITS-1:0] core_block_msg,
    input  logic [TAG_BITS-1:0]          core_tag,
    output logic [TAG_BITS-1:0]          tag,
    output logic                         tag_valid,
`ifdef HMAC_SEQ_TAG_VERIFY_EN
    input  logic [TAG_BITS-1:0]          exp_tag,
    output logic                         tag_match,
    output logic                         tag_mismatch,
`endif
    output logic                         busy
);

    localparam int PTR_W = $clog2(BLK_WORDS);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(BLK_WORDS - 1);

    seq_state_t            state_q, state_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [PTR_W+2:0]      pad_pos_q, pad_pos_d;
    logic [1:0]            hold_q, hold_d;
    logic                  first_q, first_d;
    logic                  final_q, final_d;
    logic                  extra_q, extra_d;
    logic                  pad_pend_q, pad_pend_d;
    logic                  init_q, init_d;
    logic                  next_q, next_d;
    logic                  s_ready_q, s_ready_d;
    logic                  busy_q, busy_d;
    logic                  tag_valid_q, tag_valid_d;
    logic [TAG_BITS-1:0]   tag_q, tag_d;
    logic [WORD_W-1:0]     buf_q [BLK_WORDS];
    logic [WORD_W-1:0]     buf_d [BLK_WORDS];
`ifdef HMAC_SEQ_TAG_VERIFY_EN
    logic                  match_q, match_d;
    logic                  mismatch_q, mismatch_d;
    logic                  differs_s;
`endif

    logic                  accept_s;
    logic [31:0]           pad_word_s;
    logic [2:0]            nbytes_s;
    logic [PTR_W+2:0]      pad_pos_s;
    logic                  spill_s;
    logic                  spill_extra_s;
    logic                  fits_s;
    logic [LEN_FIELD_BITS-1:0] len_s;

    hmac_seq_padder #(
        .LEN_W (LEN_W),
        .PTR_W (PTR_W)
    ) u_padder (
        .data_i        (s_data),
        .last_bytes_i  (s_last_bytes),
        .wptr_i        (wptr_q),
        .cnt_i         (cnt_q),
        .pad_pos_i     (pad_pos_q),
        .pad_word_o    (pad_word_s),
        .nbytes_o      (nbytes_s),
        .pad_pos_o     (pad_pos_s),
        .spill_o       (spill_s),
        .spill_extra_o (spill_extra_s),
        .fits_o        (fits_s),
        .len_o         (len_s)
    );

    assign accept_s = s_valid && s_ready_q;

    // Next-state logic for the FSM, block buffer and result registers.
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        cnt_d       = cnt_q;
        pad_pos_d   = pad_pos_q;
        hold_d      = hold_q;
        first_d     = first_q;
        final_d     = final_q;
        extra_d     = extra_q;
        pad_pend_d  = pad_pend_q;
        init_d      = 1'b0;
        next_d      = 1'b0;
        busy_d      = busy_q;
        tag_valid_d = tag_valid_q;
        tag_d       = tag_q;
`ifdef HMAC_SEQ_TAG_VERIFY_EN
        match_d     = match_q;
        mismatch_d  = mismatch_q;
        differs_s   = tag_differs(core_tag, exp_tag);
`endif
        for (int i = 0; i < BLK_WORDS; i++) begin
            buf_d[i] = buf_q[i];
        end

        case (state_q)
            ST_IDLE, ST_FILL: begin
                if (accept_s) begin
                    if (state_q == ST_IDLE) begin
                        tag_valid_d = 1'b0;
                        busy_d      = 1'b1;
`ifdef HMAC_SEQ_TAG_VERIFY_EN
                        match_d     = 1'b0;
                        mismatch_d  = 1'b0;
`endif
                    end else begin
                        busy_d = 1'b1;
                    end
                    if (s_last) begin
                        // Everything after the final word becomes padding.
                        for (int i = 0; i < BLK_WORDS; i++) begin
                            buf_d[i] = (i > int'(wptr_q)) ? '0 : buf_q[i];
                        end
                        buf_d[wptr_q] = pad_word_s;
                        buf_d[wptr_q + PTR_W'(1)] = (spill_s && !spill_extra_s) ?
                                                    PAD_WORD : buf_d[wptr_q + PTR_W'(1)];
                        pad_pend_d = spill_extra_s;
                        pad_pos_d  = pad_pos_s;
                        cnt_d      = cnt_q + LEN_W'(nbytes_s);
                        state_d    = ST_PADCHK;
                    end else begin
                        buf_d[wptr_q] = s_data;
                        cnt_d   = cnt_q + LEN_W'(3'd4);
                        wptr_d  = wptr_q + PTR_W'(1);
                        state_d = (wptr_q == LAST_SLOT) ? ST_ISSUE : ST_FILL;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_PADCHK: begin
                if (fits_s) begin
                    buf_d[BLK_WORDS-4] = len_s[127:96];
                    buf_d[BLK_WORDS-3] = len_s[95:64];
                    buf_d[BLK_WORDS-2] = len_s[63:32];
                    buf_d[BLK_WORDS-1] = len_s[31:0];
                    final_d = 1'b1;
                    extra_d = 1'b0;
                end else begin
                    final_d = 1'b0;
                    extra_d = 1'b1;
                end
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (core_ready) begin
                    init_d  = first_q;
                    next_d  = !first_q;
                    first_d = 1'b0;
                    hold_d  = 2'd2;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                // The core's ready/valid are stale until it has seen the command.
                if (hold_q != 2'd0) begin
                    hold_d = hold_q - 2'd1;
                end else if (core_ready && core_tag_valid) begin
                    if (final_q) begin
                        state_d = ST_DONE;
                    end else begin
                        for (int i = 0; i < BLK_WORDS; i++) begin
                            buf_d[i] = '0;
                        end
                        wptr_d  = '0;
                        state_d = extra_q ? ST_EXTRA : ST_FILL;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_EXTRA: begin
                buf_d[0]           = pad_pend_q ? PAD_WORD : '0;
                buf_d[BLK_WORDS-4] = len_s[127:96];
                buf_d[BLK_WORDS-3] = len_s[95:64];
                buf_d[BLK_WORDS-2] = len_s[63:32];
                buf_d[BLK_WORDS-1] = len_s[31:0];
                final_d    = 1'b1;
                extra_d    = 1'b0;
                pad_pend_d = 1'b0;
                state_d    = ST_ISSUE;
            end
            ST_DONE: begin
`ifdef HMAC_SEQ_TAG_VERIFY_EN
                tag_d      = differs_s ? '0 : core_tag;
                match_d    = !differs_s;
                mismatch_d = differs_s;
`else
                tag_d      = core_tag;
`endif
                tag_valid_d = 1'b1;
                busy_d      = 1'b0;
                first_d     = 1'b1;
                cnt_d       = '0;
                final_d     = 1'b0;
                wptr_d      = '0;
                for (int i = 0; i < BLK_WORDS; i++) begin
                    buf_d[i] = '0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        s_ready_d = (state_d == ST_IDLE) || (state_d == ST_FILL);
    end

    // Control and result registers; zeroize clears everything like reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wptr_q      <= '0;
            cnt_q       <= '0;
            pad_pos_q   <= '0;
            hold_q      <= 2'd0;
            first_q     <= 1'b1;
            final_q     <= 1'b0;
            extra_q     <= 1'b0;
            pad_pend_q  <= 1'b0;
            init_q      <= 1'b0;
            next_q      <= 1'b0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            tag_valid_q <= 1'b0;
            tag_q       <= '0;
`ifdef HMAC_SEQ_TAG_VERIFY_EN
            match_q     <= 1'b0;
            mismatch_q  <= 1'b0;
`endif
        end else if (zeroize) begin
            state_q     <= ST_IDLE;
            wptr_q      <= '0;
            cnt_q       <= '0;
            pad_pos_q   <= '0;
            hold_q      <= 2'd0;
            first_q     <= 1'b1;
            final_q     <= 1'b0;
            extra_q     <= 1'b0;
            pad_pend_q  <= 1'b0;
            init_q      <= 1'b0;
            next_q      <= 1'b0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            tag_valid_q <= 1'b0;
            tag_q       <= '0;
`ifdef HMAC_SEQ_TAG_VERIFY_EN
            match_q     <= 1'b0;
            mismatch_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            cnt_q       <= cnt_d;
            pad_pos_q   <= pad_pos_d;
            hold_q      <= hold_d;
            first_q     <= first_d;
            final_q     <= final_d;
            extra_q     <= extra_d;
            pad_pend_q  <= pad_pend_d;
            init_q      <= init_d;
            next_q      <= next_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            tag_valid_q <= tag_valid_d;
            tag_q       <= tag_d;
`ifdef HMAC_SEQ_TAG_VERIFY_EN
            match_q     <= match_d;
            mismatch_q  <= mismatch_d;
`endif
        end
    end

    // Block buffer storage; held stable while the core consumes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BLK_WORDS; i++) begin
                buf_q[i] <= '0;
            end
        end else if (zeroize) begin
            for (int i = 0; i < BLK_WORDS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BLK_WORDS; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    // Flatten the buffer with word 0 in the most significant position.
    always_comb begin
        core_block_msg = '0;
        for (int i = 0; i < BLK_WORDS; i++) begin
            core_block_msg[SHA384_BLOCK_BITS-1-WORD_W*i -: WORD_W] = buf_q[i];
        end
    end

    assign s_ready       = s_ready_q;
    assign core_init_cmd = init_q;
    assign core_next_cmd = next_q;
    assign busy          = busy_q;
    assign tag_valid     = tag_valid_q;
    assign tag           = tag_q;
`ifdef HMAC_SEQ_TAG_VERIFY_EN
    assign tag_match     = match_q;
    assign tag_mismatch  = mismatch_q;
`endif

endmodule

// File: tb/tb_hmac_msg_sequencer.sv
// Directed testbench for hmac_msg_sequencer with a simple core stand-in that
// latches each issued block and answers with a programmable tag.
module tb_hmac_msg_sequencer;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           zeroize;
    logic           s_valid;
    logic           s_ready;
    logic [31:0]    s_data;
    logic           s_last;
    logic [1:0]     s_last_bytes;
    logic           core_init_cmd;
    logic           core_next_cmd;
    logic           core_ready;
    logic           core_tag_valid;
    logic [1023:0]  core_block_msg;
    logic [383:0]   core_tag;
    logic [383:0]   tag;
    logic           tag_valid;
    logic           busy;
`ifdef HMAC_SEQ_TAG_VERIFY_EN
    logic [383:0]   exp_tag;
    logic           tag_match;
    logic           tag_mismatch;
`endif

    int             n_assert = 0;
    int             n_fail   = 0;
    logic [383:0]   mock_tag;
    int             lat;
    logic [1023:0]  cap_blk [0:31];
    logic           cap_init [0:31];
    int             ncmd = 0;

    always #5 clk = ~clk;

    assign core_tag = mock_tag;

    hmac_msg_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .zeroize        (zeroize),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_last         (s_last),
        .s_last_bytes   (s_last_bytes),
        .core_init_cmd  (core_init_cmd),
        .core_next_cmd  (core_next_cmd),
        .core_ready     (core_ready),
        .core_tag_valid (core_tag_valid),
        .core_block_msg (core_block_msg),
        .core_tag       (core_tag),
        .tag            (tag),
        .tag_valid      (tag_valid),
`ifdef HMAC_SEQ_TAG_VERIFY_EN
        .exp_tag        (exp_tag),
        .tag_match      (tag_match),
        .tag_mismatch   (tag_mismatch),
`endif
        .busy           (busy)
    );

    // Core stand-in: goes busy on a command, answers after a few cycles.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n || zeroize) begin
            core_ready     <= 1'b1;
            core_tag_valid <= 1'b0;
            lat            <= 0;
        end else if (core_init_cmd || core_next_cmd) begin
            core_ready     <= 1'b0;
            core_tag_valid <= 1'b0;
            lat            <= 4;
        end else if (lat != 0) begin
            lat <= lat - 1;
            if (lat == 1) begin
                core_ready     <= 1'b1;
                core_tag_valid <= 1'b1;
            end
        end
    end

    // Command monitor: capture blocks, check exclusivity and input hold-off.
    always @(negedge clk) begin
        if (reset_n) begin
            if (core_init_cmd || core_next_cmd) begin
                n_assert++;
                if (core_init_cmd && core_next_cmd) begin
                    n_fail++;
                    $display("FAIL cmd_exclusive: init=%b next=%b, required one-hot", core_init_cmd, core_next_cmd);
                end
                if (ncmd < 32) begin
                    cap_blk[ncmd]  = core_block_msg;
                    cap_init[ncmd] = core_init_cmd;
                end
                ncmd++;
            end
            if (!core_ready) begin
                n_assert++;
                if (s_ready) begin
                    n_fail++;
                    $display("FAIL sready_during_core_op: s_ready=%b required 0", s_ready);
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic l, input logic [1:0] lb);
        int n;
        s_data = d; s_last = l; s_last_bytes = lb; s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            n_assert++; n_fail++;
            $display("FAIL send_timeout: s_ready=%b required 1 within 1000 cycles", s_ready);
        end else begin
            @(negedge clk);
        end
        s_valid = 1'b0; s_last = 1'b0; s_last_bytes = 2'd0;
    endtask

    task automatic wait_tag();
        int n;
        n = 0;
        while (!tag_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        n_assert++;
        if (!tag_valid) begin
            n_fail++;
            $display("FAIL tag_timeout: tag_valid=%b required 1 within 1000 cycles", tag_valid);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; zeroize = 1'b0; s_valid = 1'b0; s_data = 32'h0;
        s_last = 1'b0; s_last_bytes = 2'd0; mock_tag = '0;
`ifdef HMAC_SEQ_TAG_VERIFY_EN
        exp_tag = '0;
`endif
        repeat (3) @(negedge clk);
        n_assert++;
        if ({s_ready, core_init_cmd, core_next_cmd, tag_valid, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 00000", {s_ready, core_init_cmd, core_next_cmd, tag_valid, busy});
        end
        n_assert++;
        if (tag !== 384'd0 || core_block_msg !== 1024'd0) begin
            n_fail++;
            $display("FAIL reset_data: tag=%h required 0", tag);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_assert++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ready: s_ready=%b required 1", s_ready);
        end
    endtask

    task automatic test_abc();
        logic [1023:0] exp;
        int c0;
        c0 = ncmd;
        mock_tag = {12{32'hABC00001}};
        send_word(32'h61626300, 1'b1, 2'd3);
        wait_tag();
        exp = '0; exp[1023:992] = 32'h61626380; exp[127:0] = 128'h418;
        n_assert++;
        if (ncmd - c0 !== 1 || cap_init[c0] !== 1'b1) begin
            n_fail++;
            $display("FAIL abc_cmds: count=%0d init=%b required 1 init", ncmd - c0, cap_init[c0]);
        end
        n_assert++;
        if (cap_blk[c0] !== exp) begin
            n_fail++;
            $display("FAIL abc_block: got %h required %h", cap_blk[c0], exp);
        end
        n_assert++;
        if (tag !== mock_tag || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abc_tag: tag=%h busy=%b required %h busy 0", tag, busy, mock_tag);
        end
    endtask

    task automatic test_112();
        logic [1023:0] exp0, exp1;
        int c0;
        c0 = ncmd;
        mock_tag = {12{32'h11200002}};
        exp0 = '0; exp1 = '0;
        for (int i = 0; i < 28; i++) begin
            exp0[1023-32*i -: 32] = 32'hA5000000 | 32'(i);
            send_word(32'hA5000000 | 32'(i), (i == 27), 2'd0);
        end
        exp0[1023-32*28 -: 32] = 32'h80000000;
        exp1[127:0] = 128'h780;
        wait_tag();
        n_assert++;
        if (ncmd - c0 !== 2 || cap_init[c0] !== 1'b1 || cap_init[c0+1] !== 1'b0) begin
            n_fail++;
            $display("FAIL m112_cmds: count=%0d init=%b%b required 2 init,next", ncmd - c0, cap_init[c0], cap_init[c0+1]);
        end
        n_assert++;
        if (cap_blk[c0] !== exp0) begin
            n_fail++;
            $display("FAIL m112_block0: got %h required %h", cap_blk[c0], exp0);
        end
        n_assert++;
        if (cap_blk[c0+1] !== exp1) begin
            n_fail++;
            $display("FAIL m112_block1: got %h required %h", cap_blk[c0+1], exp1);
        end
        n_assert++;
        if (tag !== mock_tag) begin
            n_fail++;
            $display("FAIL m112_tag: got %h required %h", tag, mock_tag);
        end
    endtask

    task automatic test_256();
        logic [1023:0] exp0, exp1, exp2;
        int c0;
        c0 = ncmd;
        mock_tag = {12{32'h25600003}};
        exp0 = '0; exp1 = '0; exp2 = '0;
        for (int i = 0; i < 32; i++) begin
            exp0[1023-32*i -: 32] = 32'h5A000000 | 32'(i);
            exp1[1023-32*i -: 32] = 32'h5A000000 | 32'(i + 32);
        end
        exp2[1023:992] = 32'h80000000;
        exp2[127:0]    = 128'hC00;
        for (int i = 0; i < 64; i++) begin
            send_word(32'h5A000000 | 32'(i), (i == 63), 2'd0);
        end
        wait_tag();
        n_assert++;
        if (ncmd - c0 !== 3 || cap_init[c0] !== 1'b1 || cap_init[c0+1] !== 1'b0 || cap_init[c0+2] !== 1'b0) begin
            n_fail++;
            $display("FAIL m256_cmds: count=%0d required 3 (init,next,next)", ncmd - c0);
        end
        n_assert++;
        if (cap_blk[c0] !== exp0 || cap_blk[c0+1] !== exp1) begin
            n_fail++;
            $display("FAIL m256_data_blocks: got %h required %h", cap_blk[c0+1], exp1);
        end
        n_assert++;
        if (cap_blk[c0+2] !== exp2) begin
            n_fail++;
            $display("FAIL m256_block2: got %h required %h", cap_blk[c0+2], exp2);
        end
        n_assert++;
        if (tag !== mock_tag) begin
            n_fail++;
            $display("FAIL m256_tag: got %h required %h", tag, mock_tag);
        end
    endtask

    task automatic test_back_to_back();
        logic [1023:0] exp1, exp2;
        logic [383:0]  t1, t2;
        int c0;
        c0 = ncmd;
        t1 = {12{32'hB2B00001}};
        t2 = {12{32'hB2B00002}};
        mock_tag = t1;
        send_word(32'h61626364, 1'b0, 2'd0);
        send_word(32'h65666700, 1'b1, 2'd3);
        wait_tag();
        n_assert++;
        if (tag !== t1) begin
            n_fail++;
            $display("FAIL b2b_tag1: got %h required %h", tag, t1);
        end
        mock_tag = t2;
        send_word(32'h7A000000, 1'b1, 2'd1);
        n_assert++;
        if (tag_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_valid_drop: tag_valid=%b busy=%b required 0,1", tag_valid, busy);
        end
        wait_tag();
        exp1 = '0; exp1[1023:960] = 64'h6162636465666780; exp1[127:0] = 128'h438;
        exp2 = '0; exp2[1023:992] = 32'h7A800000;        exp2[127:0] = 128'h408;
        n_assert++;
        if (tag !== t2) begin
            n_fail++;
            $display("FAIL b2b_tag2: got %h required %h", tag, t2);
        end
        n_assert++;
        if (ncmd - c0 !== 2 || cap_init[c0] !== 1'b1 || cap_init[c0+1] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_cmds: count=%0d init=%b%b required 2 both init", ncmd - c0, cap_init[c0], cap_init[c0+1]);
        end
        n_assert++;
        if (cap_blk[c0] !== exp1 || cap_blk[c0+1] !== exp2) begin
            n_fail++;
            $display("FAIL b2b_blocks: got %h required %h", cap_blk[c0+1], exp2);
        end
    endtask

    task automatic test_zeroize();
        logic [1023:0] exp;
        int c0, c1, n;
        c0 = ncmd;
        mock_tag = {12{32'h2E200004}};
        send_word(32'h61626300, 1'b1, 2'd3);
        n = 0;
        while (ncmd == c0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_assert++;
        if (ncmd == c0) begin
            n_fail++;
            $display("FAIL zeroize_cmd_timeout: commands=%0d required %0d", ncmd - c0, 1);
        end
        zeroize = 1'b1;
        @(negedge clk);
        n_assert++;
        if ({s_ready, core_init_cmd, core_next_cmd, tag_valid, busy} !== 5'b0 ||
            tag !== 384'd0 || core_block_msg !== 1024'd0) begin
            n_fail++;
            $display("FAIL zeroize_outputs: ctrl=%b tag=%h required all zero",
                     {s_ready, core_init_cmd, core_next_cmd, tag_valid, busy}, tag);
        end
        zeroize = 1'b0;
        c1 = ncmd;
        repeat (20) @(negedge clk);
        n_assert++;
        if (ncmd !== c1 || tag_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zeroize_quiet: extra cmds=%0d tag_valid=%b required 0,0", ncmd - c1, tag_valid);
        end
        mock_tag = {12{32'h2E200005}};
        send_word(32'h61626300, 1'b1, 2'd3);
        wait_tag();
        exp = '0; exp[1023:992] = 32'h61626380; exp[127:0] = 128'h418;
        n_assert++;
        if (tag !== mock_tag || cap_init[c1] !== 1'b1 || cap_blk[c1] !== exp) begin
            n_fail++;
            $display("FAIL zeroize_recover: tag=%h init=%b required %h init 1", tag, cap_init[c1], mock_tag);
        end
    endtask

`ifdef HMAC_SEQ_TAG_VERIFY_EN
    task automatic test_verify();
        mock_tag = {12{32'h7E570006}};
        exp_tag  = mock_tag;
        send_word(32'h61626300, 1'b1, 2'd3);
        wait_tag();
        n_assert++;
        if (tag_match !== 1'b1 || tag_mismatch !== 1'b0 || tag !== mock_tag) begin
            n_fail++;
            $display("FAIL verify_match: match=%b mismatch=%b tag=%h required 1,0,%h", tag_match, tag_mismatch, tag, mock_tag);
        end
        exp_tag = mock_tag ^ (384'd1 << 200);
        send_word(32'h61626300, 1'b1, 2'd3);
        wait_tag();
        n_assert++;
        if (tag_match !== 1'b0 || tag_mismatch !== 1'b1 || tag !== 384'd0) begin
            n_fail++;
            $display("FAIL verify_mismatch: match=%b mismatch=%b tag=%h required 0,1,0", tag_match, tag_mismatch, tag);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_abc();
        test_112();
        test_256();
        test_back_to_back();
        test_zeroize();
`ifdef HMAC_SEQ_TAG_VERIFY_EN
        test_verify();
`endif
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
